piso_tx: RTL and testbench

- Parallel-in, serial-out transmitter: the read-out end of the team's loadable parallel register.
- Captures a WIDTH-bit word on a load strobe and shifts it out on one serial line as a framed sequence: start bit, data bits, stop bit.
- Sits between a parallel data source (the loadable register) and a single-wire link, to be decoded by a matching serial receiver.

---
 rtl/piso_tx_pkg.sv | 21 ++
 rtl/piso_shift_reg.sv | 37 +++
 rtl/piso_tx.sv | 104 ++++++++++
 tb/tb_piso_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso serial link: FSM state encoding and line levels.
// The matching receiver imports this package so both ends agree on framing.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // One spare bit keeps the bit counter wide enough for WIDTH=1.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register feeding the serial line; bit_o is the bit currently at the
// outgoing end, selected by MSB_FIRST.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = d_i;
        end else if (shift_i) begin
            q_d = MSB_FIRST ? (q_q << 1) : (q_q >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bit_o = MSB_FIRST ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: frames a captured WIDTH-bit word as
// start bit, data bits, stop bit on a single registered line.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;

    logic sr_load;
    logic sr_shift;
    logic sr_bit;

    // The register advances on the same edge that copies its outgoing bit onto
    // sout_q, so the line always shows the bit that was at the end one cycle earlier.
    assign sr_load  = (state_q == IDLE) && load;
    assign sr_shift = (state_q == START) || (state_q == SHIFT);

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .d_i     (d),
        .bit_o   (sr_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sout_q  <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sout_q <= IDLE_LEVEL;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (load) begin
                        state_q <= START;
                        sout_q  <= START_LEVEL;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    state_q <= SHIFT;
                    cnt_q   <= '0;
                    sout_q  <= sr_bit;
                    busy_q  <= 1'b1;
                end
                SHIFT: begin
                    busy_q <= 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= STOP;
                        sout_q  <= STOP_LEVEL;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        sout_q <= sr_bit;
                    end
                end
                STOP: begin
                    state_q <= IDLE;
                    sout_q  <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sout_q  <= IDLE_LEVEL;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: one MSB-first and one LSB-first instance, expected
// line cycles queued by the stimulus and consumed by per-instance monitors.
module tb_piso_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_m, load_l;
    logic [W-1:0] d_m, d_l;
    logic         sout_m, busy_m, done_m;
    logic         sout_l, busy_l, done_l;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Each entry is {expected sout, expected done} for one busy cycle.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk  (clk),
        .rst  (rst),
        .load (load_m),
        .d    (d_m),
        .sout (sout_m),
        .busy (busy_m),
        .done (done_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk  (clk),
        .rst  (rst),
        .load (load_l),
        .d    (d_l),
        .sout (sout_l),
        .busy (busy_l),
        .done (done_l)
    );

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq lists the busy-cycle sout values first-to-last; done is expected on the last.
    task automatic push_frame(input bit lsb, input logic [W+1:0] seq);
        for (int i = W + 1; i >= 0; i--) begin
            if (lsb) q_l.push_back({seq[i], (i == 0)});
            else     q_m.push_back({seq[i], (i == 0)});
        end
    endtask

    task automatic check_idle_now(input string name);
        check({name, "_sout"}, sout_m, 1'b1);
        check({name, "_busy"}, busy_m, 1'b0);
        check({name, "_done"}, done_m, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy_m) begin
                check("msb_frame_expected", q_m.size() != 0, 1'b1);
                if (q_m.size() != 0) begin
                    logic [1:0] e;
                    e = q_m.pop_front();
                    check("msb_sout", sout_m, e[1]);
                    check("msb_done", done_m, e[0]);
                end
            end else begin
                check("msb_idle_sout", sout_m, 1'b1);
                check("msb_idle_done", done_m, 1'b0);
                check("msb_frame_complete", q_m.size() == 0, 1'b1);
            end
            if (busy_l) begin
                check("lsb_frame_expected", q_l.size() != 0, 1'b1);
                if (q_l.size() != 0) begin
                    logic [1:0] e;
                    e = q_l.pop_front();
                    check("lsb_sout", sout_l, e[1]);
                    check("lsb_done", done_l, e[0]);
                end
            end else begin
                check("lsb_idle_sout", sout_l, 1'b1);
                check("lsb_idle_done", done_l, 1'b0);
                check("lsb_frame_complete", q_l.size() == 0, 1'b1);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        load_m = 1'b1;
        load_l = 1'b1;
        d_m    = 4'b1111;
        d_l    = 4'b1111;

        // Reset dominates load for two edges.
        tick();
        check_idle_now("rst1");
        tick();
        check_idle_now("rst2");
        rst    = 1'b0;
        load_m = 1'b0;
        load_l = 1'b0;
        mon_en = 1'b1;
        repeat (4) tick();

        // Basic MSB-first frame.
        d_m = 4'b1100; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        push_frame(1'b0, 6'b011001);
        repeat (W + 3) tick();

        // LSB-first frame.
        d_l = 4'b1000; load_l = 1'b1;
        tick();
        load_l = 1'b0;
        push_frame(1'b1, 6'b000011);
        repeat (W + 3) tick();

        // Load during the 2nd data bit is dropped.
        d_m = 4'b1010; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        push_frame(1'b0, 6'b010101);
        tick();
        tick();
        d_m = 4'b0101; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        repeat (W + 3) tick();

        // Source word changes right after capture.
        d_m = 4'b1001; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        d_m    = 4'b0110;
        push_frame(1'b0, 6'b010011);
        repeat (W + 3) tick();

        // Reset during the 3rd data bit aborts the frame.
        d_m = 4'b1111; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        q_m.push_back(2'b00);
        q_m.push_back(2'b10);
        q_m.push_back(2'b10);
        q_m.push_back(2'b10);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_now("abort");
        repeat (3) tick();

        // A clean frame follows the aborted one.
        d_m = 4'b0011; load_m = 1'b1;
        tick();
        load_m = 1'b0;
        push_frame(1'b0, 6'b000111);
        repeat (W + 4) tick();

        check("msb_queue_drained", q_m.size() == 0, 1'b1);
        check("lsb_queue_drained", q_l.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
